register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning register width in bits; must be even and >= 4.
REQ-002 The block SHALL have parameter NREG, default 4, meaning number of registers; must be >= 2.
REQ-003 The block SHALL have parameter SATURATE, default 0, meaning 0 = increment/decrement wraps, 1 = increment/decrement clamps at all-ones/zero.
REQ-004 The block SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port I  input  WIDTH  write data.
REQ-007 The block SHALL have port FunSel  input  3  operation applied to every enabled register.
REQ-008 The block SHALL have port RegSel  input  NREG  per-register enable mask; bit k enables register k; any number of bits may be set.
REQ-009 The block SHALL have port ClrWrap  input  NREG  per-register sticky Wrap-flag clear.
REQ-010 The block SHALL have ports OutASel, OutBSel  input  clog2(NREG)  read-port selects.
REQ-011 The block SHALL have ports OutA, OutB  output  WIDTH  combinational read of the selected register's current Q; selects >= NREG return 0.
REQ-012 The block SHALL have port Zero  output  NREG  bit k = 1 when register k equals 0, derived from current Q.
REQ-013 The block SHALL have port Wrap  output  NREG  registered sticky flag per register.

Function
REQ-014 Let H = WIDTH/2. For enabled register k, FunSel SHALL select: 000 Q-1; 001 Q+1; 010 load I; 011 clear to 0; 100 {H zeros, I[H-1:0]}; 101 Q[H-1:0] <= I[H-1:0], upper half held; 110 Q[WIDTH-1:H] <= I[H-1:0], lower half held; 111 {H copies of I[H-1], I[H-1:0]}.
REQ-015 A register whose RegSel bit is 0 SHALL hold Q and Wrap, except that ClrWrap still clears Wrap.
REQ-016 Increment and decrement SHALL be modulo 2^WIDTH when SATURATE=0.
REQ-017 When SATURATE=1, increment of all-ones and decrement of 0 SHALL leave Q unchanged.
REQ-018 Wrap[k] SHALL be set on the edge where register k executes increment from all-ones or decrement from 0, in either SATURATE mode.
REQ-019 Wrap[k] SHALL be cleared by ClrWrap[k]=1, by FunSel 010/011/100/111 on enabled register k, or by reset.
REQ-020 When a Wrap set event and ClrWrap[k] occur in the same cycle, Wrap[k] SHALL end set.
REQ-021 Partial loads 101/110 SHALL NOT change Wrap.
REQ-022 Writes SHALL take effect one Clock edge after inputs are presented.
REQ-023 Read ports SHALL show pre-edge values in the write cycle; there is no write-through bypass.
REQ-024 OutA and OutB SHALL be allowed to select the same register.

Reset
REQ-025 While Reset=0, all Q SHALL be 0, all Wrap SHALL be 0, and Zero SHALL be all-ones, asynchronously and independent of Clock.
REQ-026 Reset asserted mid-operation SHALL abort any pending write.
REQ-027 The first write after Reset deasserts SHALL occur at the first rising edge with Reset=1.

Structure
REQ-028 FunSel encodings SHALL be named constants in shared package register_bank_pkg, reused by the decoder and the bench.
REQ-029 Sub-module register_cell SHALL hold one WIDTH-bit register plus its Wrap flag.
REQ-030 register_bank SHALL instantiate register_cell NREG times and add the read muxes and Zero logic.
REQ-031 Parameter legality (WIDTH even, WIDTH >= 4, NREG >= 2) SHALL be checked at elaboration.

Verification (WIDTH=16, NREG=4 unless stated)
REQ-032 Reset, then RegSel=0001, FunSel=000 -> R0=0xFFFF, Wrap=0001; then ClrWrap=0001 -> Wrap=0000.
REQ-033 SATURATE=1, R1=0xFFFF, FunSel=001 on R1 -> R1 stays 0xFFFF, Wrap[1]=1.
REQ-034 I=0x12F0, RegSel=1100, FunSel=111 -> R2=R3=0xFFF0; then FunSel=110 with I=0x0034 on R2 -> R2=0x34F0.
REQ-035 R0=0xFFFF, FunSel=001 and ClrWrap[0]=1 in the same cycle -> R0=0x0000, Wrap[0]=1, Zero[0]=1.
REQ-036 Write 0xABCD to R2 with OutASel=OutBSel=2 -> both outputs show old value in the write cycle and 0xABCD after the edge.
REQ-037 Assert Reset between edges during a load -> all Q=0 immediately, with no load applied at the next edge.

Source files
------------

// File: rtl/register_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_pkg
// Description : Shared FunSel operation encodings for the register bank and
//               its per-register cell. Other files reach these constants
//               with import register_bank_pkg::*.
// Revision    : 1.0 - initial release
// ============================================================================
package register_bank_pkg;

    localparam int c_FUNSEL_W = 3;

    localparam logic [c_FUNSEL_W-1:0] c_FS_DEC     = 3'b000; // Q - 1
    localparam logic [c_FUNSEL_W-1:0] c_FS_INC     = 3'b001; // Q + 1
    localparam logic [c_FUNSEL_W-1:0] c_FS_LOAD    = 3'b010; // Q <= I
    localparam logic [c_FUNSEL_W-1:0] c_FS_CLR     = 3'b011; // Q <= 0
    localparam logic [c_FUNSEL_W-1:0] c_FS_ZEXT    = 3'b100; // zero-extended low half of I
    localparam logic [c_FUNSEL_W-1:0] c_FS_LOAD_LO = 3'b101; // low half <= I low half
    localparam logic [c_FUNSEL_W-1:0] c_FS_LOAD_HI = 3'b110; // high half <= I low half
    localparam logic [c_FUNSEL_W-1:0] c_FS_SEXT    = 3'b111; // sign-extended low half of I

    // FunSel codes that reset the sticky Wrap flag of an enabled register.
    function automatic logic fs_clears_wrap(input logic [c_FUNSEL_W-1:0] fs);
        return (fs == c_FS_LOAD) || (fs == c_FS_CLR) ||
               (fs == c_FS_ZEXT) || (fs == c_FS_SEXT);
    endfunction

endpackage : register_bank_pkg
`default_nettype wire

// File: rtl/register_cell.sv
`default_nettype none
// ============================================================================
// Module      : register_cell
// Description : One WIDTH-bit register plus its sticky Wrap flag.
//   Clock   in   rising-edge clock
//   Reset   in   asynchronous active-low reset
//   I       in   write data
//   FunSel  in   operation (register_bank_pkg encodings)
//   En      in   register enable; when low Q and Wrap hold
//   ClrWrap in   sticky Wrap clear (works even when En is low)
//   Q       out  current register value
//   Wrap    out  sticky wrap flag
// Revision    : 1.0 - initial release
// ============================================================================
module register_cell
    import register_bank_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [WIDTH-1:0]      I,
    input  logic [c_FUNSEL_W-1:0] FunSel,
    input  logic                  En,
    input  logic                  ClrWrap,
    output logic [WIDTH-1:0]      Q,
    output logic                  Wrap
);

    localparam int c_HALF = WIDTH / 2;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_q;
    logic             w_wrap_set;
    logic             w_all_ones;
    logic             w_is_zero;

    assign w_all_ones = &r_q;
    assign w_is_zero  = ~|r_q;

    always_comb begin
        w_next_q   = r_q;
        w_wrap_set = 1'b0;
        case (FunSel)
            c_FS_DEC: begin
                w_wrap_set = w_is_zero;
                // In saturating mode the boundary value simply holds.
                if (!(SATURATE != 0 && w_is_zero)) begin
                    w_next_q = r_q - 1'b1;
                end
            end
            c_FS_INC: begin
                w_wrap_set = w_all_ones;
                if (!(SATURATE != 0 && w_all_ones)) begin
                    w_next_q = r_q + 1'b1;
                end
            end
            c_FS_LOAD:    w_next_q = I;
            c_FS_CLR:     w_next_q = '0;
            c_FS_ZEXT:    w_next_q = {{c_HALF{1'b0}}, I[c_HALF-1:0]};
            c_FS_LOAD_LO: w_next_q = {r_q[WIDTH-1:c_HALF], I[c_HALF-1:0]};
            c_FS_LOAD_HI: w_next_q = {I[c_HALF-1:0], r_q[c_HALF-1:0]};
            c_FS_SEXT:    w_next_q = {{c_HALF{I[c_HALF-1]}}, I[c_HALF-1:0]};
            default:      w_next_q = r_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            if (En) begin
                r_q <= w_next_q;
            end
            // A new wrap event wins over any clear arriving on the same edge.
            if (En && w_wrap_set) begin
                r_wrap <= 1'b1;
            end else if (ClrWrap) begin
                r_wrap <= 1'b0;
            end else if (En && fs_clears_wrap(FunSel)) begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign Q    = r_q;
    assign Wrap = r_wrap;

endmodule : register_cell
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module      : register_bank
// Description : NREG registers of WIDTH bits sharing one FunSel operation,
//               applied to every register enabled in RegSel, with two
//               combinational read ports, per-register Zero flags and sticky
//               per-register Wrap flags.
//   Clock            in   rising-edge clock
//   Reset            in   asynchronous active-low reset
//   I                in   write data
//   FunSel           in   operation for enabled registers
//   RegSel           in   per-register enable mask
//   ClrWrap          in   per-register sticky Wrap clear
//   OutASel/OutBSel  in   read-port selects (>= NREG reads 0)
//   OutA/OutB        out  selected register value (no write bypass)
//   Zero             out  bit k set when register k is zero
//   Wrap             out  sticky wrap flags
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NREG     = 4,
    parameter int SATURATE = 0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [WIDTH-1:0]        I,
    input  logic [c_FUNSEL_W-1:0]   FunSel,
    input  logic [NREG-1:0]         RegSel,
    input  logic [NREG-1:0]         ClrWrap,
    input  logic [$clog2(NREG)-1:0] OutASel,
    input  logic [$clog2(NREG)-1:0] OutBSel,
    output logic [WIDTH-1:0]        OutA,
    output logic [WIDTH-1:0]        OutB,
    output logic [NREG-1:0]         Zero,
    output logic [NREG-1:0]         Wrap
);

    localparam int c_SEL_W = $clog2(NREG);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4 || NREG < 2 ||
            (SATURATE != 0 && SATURATE != 1)) begin : g_param_check
            $error("register_bank: illegal parameters WIDTH=%0d NREG=%0d SATURATE=%0d",
                   WIDTH, NREG, SATURATE);
        end
    endgenerate

    logic [WIDTH-1:0] w_q [NREG];

    generate
        for (genvar k = 0; k < NREG; k++) begin : g_cell
            register_cell #(
                .WIDTH    (WIDTH),
                .SATURATE (SATURATE)
            ) u_cell (
                .Clock   (Clock),
                .Reset   (Reset),
                .I       (I),
                .FunSel  (FunSel),
                .En      (RegSel[k]),
                .ClrWrap (ClrWrap[k]),
                .Q       (w_q[k]),
                .Wrap    (Wrap[k])
            );
            assign Zero[k] = (w_q[k] == '0);
        end
    endgenerate

    // Loop-based mux: a select with no matching register leaves the output 0,
    // which covers select values >= NREG when NREG is not a power of two.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NREG; k++) begin
            if (OutASel == c_SEL_W'(k)) begin
                OutA = w_q[k];
            end
            if (OutBSel == c_SEL_W'(k)) begin
                OutB = w_q[k];
            end
        end
    end

endmodule : register_bank
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_bank
// Description : Self-checking bench for register_bank (WIDTH=16, NREG=4).
//               A wrapping and a saturating instance share all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank;
    import register_bank_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] I = '0;
    logic [2:0]  FunSel = '0;
    logic [3:0]  RegSel = '0;
    logic [3:0]  ClrWrap = '0;
    logic [1:0]  OutASel = '0;
    logic [1:0]  OutBSel = '0;
    logic [15:0] outa0, outb0, outa1, outb1;
    logic [3:0]  zero0, wrap0, zero1, wrap1;

    always #5 Clock = ~Clock;

    register_bank #(.WIDTH(16), .NREG(4), .SATURATE(0)) dut (
        .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
        .ClrWrap(ClrWrap), .OutASel(OutASel), .OutBSel(OutBSel),
        .OutA(outa0), .OutB(outb0), .Zero(zero0), .Wrap(wrap0));

    register_bank #(.WIDTH(16), .NREG(4), .SATURATE(1)) dut_sat (
        .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
        .ClrWrap(ClrWrap), .OutASel(OutASel), .OutBSel(OutBSel),
        .OutA(outa1), .OutB(outb1), .Zero(zero1), .Wrap(wrap1));

    int checks = 0;
    int passes = 0;

    // Reference model: index 0 = wrapping instance, 1 = saturating instance.
    int unsigned mq [2][4];
    bit          mw [2][4];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                mq[d][k] = 0;
                mw[d][k] = 0;
            end
    endtask

    // Arithmetic view of one clock edge for both instances.
    task automatic model_apply(input int unsigned f, input bit [3:0] s,
                               input bit [3:0] c, input int unsigned din);
        int unsigned q, nq, lo;
        bit set_ev, clr_op, sat;
        lo = din % 256;
        for (int d = 0; d < 2; d++) begin
            sat = (d == 1);
            for (int k = 0; k < 4; k++) begin
                q = mq[d][k];
                nq = q;
                set_ev = 0;
                clr_op = 0;
                case (f)
                    0: if (q == 0) begin set_ev = 1; nq = sat ? 0 : 65535; end
                       else nq = q - 1;
                    1: if (q == 65535) begin set_ev = 1; nq = sat ? 65535 : 0; end
                       else nq = q + 1;
                    2: begin nq = din; clr_op = 1; end
                    3: begin nq = 0; clr_op = 1; end
                    4: begin nq = lo; clr_op = 1; end
                    5: nq = (q / 256) * 256 + lo;
                    6: nq = lo * 256 + q % 256;
                    default: begin nq = (lo >= 128) ? 65280 + lo : lo; clr_op = 1; end
                endcase
                if (s[k] && set_ev)      mw[d][k] = 1;
                else if (c[k])           mw[d][k] = 0;
                else if (s[k] && clr_op) mw[d][k] = 0;
                if (s[k]) mq[d][k] = nq;
            end
        end
    endtask

    function automatic bit [3:0] model_zero(input int d);
        bit [3:0] z;
        for (int k = 0; k < 4; k++) z[k] = (mq[d][k] == 0);
        return z;
    endfunction

    function automatic bit [3:0] model_wrap(input int d);
        bit [3:0] w;
        for (int k = 0; k < 4; k++) w[k] = mw[d][k];
        return w;
    endfunction

    // Reads every register through both ports of both instances.
    task automatic check_all(input string tag);
        for (int p = 0; p < 2; p++) begin
            OutASel = 2'(2 * p);
            OutBSel = 2'(2 * p + 1);
            #1;
            chk({tag, " wrapA"}, outa0, mq[0][2*p]);
            chk({tag, " wrapB"}, outb0, mq[0][2*p+1]);
            chk({tag, " satA"},  outa1, mq[1][2*p]);
            chk({tag, " satB"},  outb1, mq[1][2*p+1]);
        end
        chk({tag, " zero"},     zero0, model_zero(0));
        chk({tag, " wrapflag"}, wrap0, model_wrap(0));
        chk({tag, " satzero"},  zero1, model_zero(1));
        chk({tag, " satwrap"},  wrap1, model_wrap(1));
    endtask

    task automatic step(input logic [2:0] f, input logic [3:0] s,
                        input logic [3:0] c, input logic [15:0] d, input string tag);
        FunSel = f; RegSel = s; ClrWrap = c; I = d;
        model_apply(f, s, c, d);
        @(posedge Clock); #1;
        RegSel = '0; ClrWrap = '0;
        check_all(tag);
    endtask

    typedef struct {
        logic [2:0]  fun;
        logic [3:0]  sel;
        logic [3:0]  clr;
        logic [15:0] din;
        logic [15:0] q [4];
        logic [3:0]  wrap;
        logic [3:0]  zero;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Expected values for the wrapping instance, starting from reset.
        tbl[0]  = '{c_FS_DEC,     4'b0001, 4'b0000, 16'h0000, '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000}, 4'b0001, 4'b1110};
        tbl[1]  = '{c_FS_DEC,     4'b0000, 4'b0001, 16'h0000, '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000}, 4'b0000, 4'b1110};
        tbl[2]  = '{c_FS_SEXT,    4'b1100, 4'b0000, 16'h12F0, '{16'hFFFF, 16'h0000, 16'hFFF0, 16'hFFF0}, 4'b0000, 4'b0010};
        tbl[3]  = '{c_FS_LOAD_HI, 4'b0100, 4'b0000, 16'h0034, '{16'hFFFF, 16'h0000, 16'h34F0, 16'hFFF0}, 4'b0000, 4'b0010};
        tbl[4]  = '{c_FS_INC,     4'b0001, 4'b0001, 16'h0000, '{16'h0000, 16'h0000, 16'h34F0, 16'hFFF0}, 4'b0001, 4'b0011};
        tbl[5]  = '{c_FS_LOAD_LO, 4'b1000, 4'b0000, 16'h1234, '{16'h0000, 16'h0000, 16'h34F0, 16'hFF34}, 4'b0001, 4'b0011};
        tbl[6]  = '{c_FS_ZEXT,    4'b0010, 4'b0000, 16'hBEEF, '{16'h0000, 16'h00EF, 16'h34F0, 16'hFF34}, 4'b0001, 4'b0001};
        tbl[7]  = '{c_FS_DEC,     4'b0011, 4'b0000, 16'h0000, '{16'hFFFF, 16'h00EE, 16'h34F0, 16'hFF34}, 4'b0001, 4'b0000};
        tbl[8]  = '{c_FS_CLR,     4'b0001, 4'b0000, 16'h0000, '{16'h0000, 16'h00EE, 16'h34F0, 16'hFF34}, 4'b0000, 4'b0001};
        tbl[9]  = '{c_FS_INC,     4'b1111, 4'b0000, 16'h0000, '{16'h0001, 16'h00EF, 16'h34F1, 16'hFF35}, 4'b0000, 4'b0000};
        tbl[10] = '{c_FS_DEC,     4'b0001, 4'b0000, 16'h0000, '{16'h0000, 16'h00EF, 16'h34F1, 16'hFF35}, 4'b0000, 4'b0001};
        tbl[11] = '{c_FS_DEC,     4'b0001, 4'b0000, 16'h0000, '{16'hFFFF, 16'h00EF, 16'h34F1, 16'hFF35}, 4'b0001, 4'b0000};
        tbl[12] = '{c_FS_LOAD,    4'b0001, 4'b0000, 16'h5555, '{16'h5555, 16'h00EF, 16'h34F1, 16'hFF35}, 4'b0000, 4'b0000};

        // Reset state
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_all("reset");
        Reset = 1'b1;

        // Directed table against hand-computed values
        for (int v = 0; v < 13; v++) begin
            FunSel = tbl[v].fun; RegSel = tbl[v].sel; ClrWrap = tbl[v].clr; I = tbl[v].din;
            model_apply(tbl[v].fun, tbl[v].sel, tbl[v].clr, tbl[v].din);
            @(posedge Clock); #1;
            RegSel = '0; ClrWrap = '0;
            for (int p = 0; p < 2; p++) begin
                OutASel = 2'(2 * p);
                OutBSel = 2'(2 * p + 1);
                #1;
                chk($sformatf("tbl%0d R%0d", v, 2*p),   outa0, tbl[v].q[2*p]);
                chk($sformatf("tbl%0d R%0d", v, 2*p+1), outb0, tbl[v].q[2*p+1]);
                chk($sformatf("tbl%0d satR%0d", v, 2*p),   outa1, mq[1][2*p]);
                chk($sformatf("tbl%0d satR%0d", v, 2*p+1), outb1, mq[1][2*p+1]);
            end
            chk($sformatf("tbl%0d wrap", v), wrap0, tbl[v].wrap);
            chk($sformatf("tbl%0d zero", v), zero0, tbl[v].zero);
            chk($sformatf("tbl%0d satwrap", v), wrap1, model_wrap(1));
            chk($sformatf("tbl%0d satzero", v), zero1, model_zero(1));
        end

        // Increment from all-ones on R1: wraps to 0 or clamps, Wrap set in both
        step(c_FS_LOAD, 4'b0010, 4'b0000, 16'hFFFF, "ld R1");
        step(c_FS_INC,  4'b0010, 4'b0000, 16'h0000, "inc R1");
        OutASel = 2'd1; #1;
        chk("inc max wrapR1", outa0, 16'h0000);
        chk("inc max satR1",  outa1, 16'hFFFF);
        chk("inc max wrap1",  wrap0[1], 1);
        chk("inc max satwrap1", wrap1[1], 1);
        // Decrement from 0 on R1
        step(c_FS_CLR, 4'b0010, 4'b0000, 16'h0000, "clr R1");
        step(c_FS_DEC, 4'b0010, 4'b0000, 16'h0000, "dec R1");
        OutASel = 2'd1; #1;
        chk("dec zero wrapR1", outa0, 16'hFFFF);
        chk("dec zero satR1",  outa1, 16'h0000);
        chk("dec zero satwrap1", wrap1[1], 1);

        // No write-through: both ports on R2 show the old value until the edge
        OutASel = 2'd2; OutBSel = 2'd2;
        FunSel = c_FS_LOAD; RegSel = 4'b0100; I = 16'hABCD;
        #1;
        chk("bypass A old", outa0, mq[0][2]);
        chk("bypass B old", outb0, mq[0][2]);
        model_apply(c_FS_LOAD, 4'b0100, 4'b0000, 16'hABCD);
        @(posedge Clock); #1;
        RegSel = '0;
        chk("bypass A new", outa0, 16'hABCD);
        chk("bypass B new", outb0, 16'hABCD);
        chk("bypass satA new", outa1, 16'hABCD);
        check_all("post bypass");

        // Reset between edges aborts a pending load
        FunSel = c_FS_LOAD; RegSel = 4'b1111; I = 16'h7777;
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        check_all("async reset");
        @(posedge Clock); #1;
        check_all("reset held edge");
        Reset = 1'b1;
        // First edge with Reset high performs the write
        model_apply(c_FS_LOAD, 4'b1111, 4'b0000, 16'h7777);
        @(posedge Clock); #1;
        RegSel = '0;
        check_all("first write");

        // Randomized traffic biased towards wrap boundaries
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  f;
            logic [15:0] d;
            case ($urandom_range(0, 3))
                0: f = 3'($urandom_range(0, 7));
                1: f = c_FS_INC;
                2: f = c_FS_DEC;
                default: f = ($urandom_range(0, 1) != 0) ? c_FS_LOAD : c_FS_CLR;
            endcase
            case ($urandom_range(0, 3))
                0: d = 16'hFFFF;
                1: d = 16'h0000;
                default: d = 16'($urandom);
            endcase
            step(f, 4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)), d,
                 $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_register_bank
`default_nettype wire
